madgwick_stream_driver: RTL and testbench
=========================================

Name: madgwick_stream_driver

Overview:
- Initiator/consumer wrapped around the madgwick filter core.
- Accepts raw IMU samples from the sensor front end and buffers them in a small FIFO.
- Drives the filter's input handshake (valid_in/ready_in) and its output handshake (valid_out/ready_out).
- Captures each normalised quaternion into a register set, with counters and a watchdog for the SweRVolf peripheral bus.

Parameters:
ACC_W, 11, accelerometer axis width (signed)
GYRO_W, 14, gyro axis width (signed)
Q_W, 16, quaternion component width (signed)
Q_ONE, 16'h4000, reset value of q_out w component (unit quaternion)
DEPTH, 4, sample FIFO depth, power of 2, >=2
CNT_W, 16, sample/drop counter width
LAT_W, 16, latency counter width
TIMEOUT, 1024, max cycles in ISSUE or COLLECT; 0 disables watchdog

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  allow FIFO push and new transactions
smp_valid  in  1  one-cycle sensor sample strobe
smp_acc  in  3*ACC_W  {z,y,x} accelerometer sample
smp_gyro  in  3*GYRO_W  {z,y,x} gyro sample
filt_valid_in  out  1  to filter valid_in
filt_ready_in  in  1  from filter ready_in
filt_acc  out  3*ACC_W  to filter a_{z,y,x}
filt_gyro  out  3*GYRO_W  to filter w_{z,y,x}
filt_valid_out  in  1  from filter valid_out
filt_ready_out  out  1  to filter ready_out
filt_q  in  4*Q_W  from filter {z,y,x,w} norm outputs
q_out  out  4*Q_W  last captured quaternion {z,y,x,w}
q_update  out  1  one-cycle pulse after q_out changes
sample_cnt  out  CNT_W  completed transactions, saturating
drop_cnt  out  CNT_W  samples dropped on FIFO full, saturating
last_latency  out  LAT_W  cycles from input handshake to output handshake
busy  out  1  FSM not IDLE or FIFO non-empty
timeout_err  out  1  sticky watchdog flag
err_clr  in  1  clears timeout_err

Behaviour:
- Reset (async, immediate):
  - FIFO empty, FSM IDLE.
  - filt_valid_in=0, filt_ready_out=0, filt_acc=0, filt_gyro=0.
  - q_out={0,0,0,Q_ONE}; q_update=0.
  - Counters and last_latency =0; timeout_err=0; busy=0.
- FIFO push:
  - Condition: smp_valid && enable && (!full || pop this cycle).
  - smp_valid && enable with full and no pop: sample dropped, drop_cnt+1 (saturate at all-ones).
  - smp_valid with enable=0: ignored, not counted.
- FSM states: IDLE, ISSUE, COLLECT.
- IDLE:
  - If enable && !empty: register FIFO head onto filt_acc/filt_gyro, set filt_valid_in=1, go ISSUE.
  - First filt_valid_in occurs 1 cycle after the push into an empty FIFO.
- ISSUE:
  - filt_valid_in and data held stable until filt_ready_in is sampled high at a posedge.
  - On that edge: pop FIFO, filt_valid_in=0, filt_ready_out=1, latency counter=0, go COLLECT.
- COLLECT:
  - Latency counter increments each cycle (saturating).
  - On a posedge with filt_valid_out && filt_ready_out: q_out<=filt_q, sample_cnt+1, last_latency<=counter+1, filt_ready_out=0, go IDLE.
  - q_update pulses high for exactly the following cycle.
  - One idle bubble between transactions is required.
- enable deasserted mid-transaction: current transaction completes; FIFO contents retained; FSM stays in IDLE until enable=1.
- Watchdog (TIMEOUT>0):
  - Cycle counter resets on entering ISSUE or COLLECT.
  - On reaching TIMEOUT: timeout_err=1, filt_valid_in=0, filt_ready_out=0, go IDLE.
  - If timeout occurs in ISSUE, the head entry is popped (discarded). Counters unchanged; q_out unchanged.
- err_clr:
  - Clears timeout_err next cycle.
  - A timeout in the same cycle as err_clr wins (flag stays set).
- Widths: all data passed through unmodified; no arithmetic on samples; counters unsigned saturating.
- Pointers: wrap modulo DEPTH; extra wrap bit distinguishes full from empty.

Decomposition:
- madgwickDefines.vh (existing shared defines) supplies ACC_WIDTH, GYRO_WIDTH and Q_WIDTH as parameter defaults.
- Add STREAM_DEPTH and STREAM_TIMEOUT to the same file.
- One sub-module: madgwick_sample_fifo.
  - Sync FIFO, width 3*ACC_W+3*GYRO_W, push/pop/full/empty, first-word-fall-through head output.

Test Plan:
- Single sample:
  - Stimulus: push acc {x=0x7B8,y=0x14A,z=0x0C4}, gyro {x=0x3F1F,y=0x005C,z=0x3F54}; model asserts ready_in 3 cycles after valid_in, valid_out 20 cycles later with q={w=0x3FFF,x=0x0010,y=0xFFF0,z=0x0002}.
  - Required: filt_acc/filt_gyro match the push; q_out matches q; one q_update pulse; sample_cnt=1; last_latency=20.
- Overflow:
  - Stimulus: DEPTH=4, model ready_in held low, 6 strobes on consecutive cycles.
  - Required: drop_cnt=2. After releasing ready_in, 4 transactions complete in push order; sample_cnt=4.
- Backpressure:
  - Stimulus: ready_in low for 50 cycles.
  - Required: filt_valid_in high and filt_acc/filt_gyro bit-stable all 50 cycles; exactly one pop.
- Watchdog:
  - Stimulus: TIMEOUT=100, model never asserts valid_out.
  - Required: after 100 cycles in COLLECT, timeout_err=1, filt_ready_out=0, FSM IDLE, sample_cnt unchanged. err_clr pulse -> timeout_err=0.
- Reset mid-COLLECT:
  - Stimulus: assert rst between clock edges.
  - Required: outputs take reset values immediately (q_out w=0x4000, others 0); busy=0.
- Push-on-full with pop:
  - Stimulus: FIFO full, smp_valid in the same cycle as the ready_in handshake.
  - Required: sample accepted, drop_cnt unchanged, FIFO stays full.

Source files
------------

// File: rtl/madgwick_stream_driver_pkg.sv
// Shared widths, depth/timeout defaults and FSM state type
// for the madgwick filter stream driver.
package madgwick_stream_driver_pkg;

    localparam int ACC_WIDTH      = 11;
    localparam int GYRO_WIDTH     = 14;
    localparam int Q_WIDTH        = 16;
    localparam int STREAM_DEPTH   = 4;
    localparam int STREAM_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_COLLECT
    } state_t;

endpackage

// File: rtl/madgwick_sample_fifo.sv
// Sync first-word-fall-through sample FIFO.
// Ports: clk/rst, push/din, pop/dout (head), full, empty.
module madgwick_sample_fifo
    import madgwick_stream_driver_pkg::*;
#(
    parameter int W     = 75,
    parameter int DEPTH = STREAM_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer separates full from empty.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    logic do_pop;
    logic do_push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/madgwick_stream_driver.sv
// Buffers IMU samples, drives the madgwick filter handshakes and
// captures quaternions with counters, latency and a watchdog.
// Ports: sample input (smp_*), filter side (filt_*),
// results (q_out, q_update, sample_cnt, drop_cnt, last_latency),
// status (busy, timeout_err, err_clr), control (enable).
module madgwick_stream_driver
    import madgwick_stream_driver_pkg::*;
#(
    parameter int          ACC_W   = ACC_WIDTH,
    parameter int          GYRO_W  = GYRO_WIDTH,
    parameter int          Q_W     = Q_WIDTH,
    parameter logic [15:0] Q_ONE   = 16'h4000,
    parameter int          DEPTH   = STREAM_DEPTH,
    parameter int          CNT_W   = 16,
    parameter int          LAT_W   = 16,
    parameter int          TIMEOUT = STREAM_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                smp_valid,
    input  logic [3*ACC_W-1:0]  smp_acc,
    input  logic [3*GYRO_W-1:0] smp_gyro,
    output logic                filt_valid_in,
    input  logic                filt_ready_in,
    output logic [3*ACC_W-1:0]  filt_acc,
    output logic [3*GYRO_W-1:0] filt_gyro,
    input  logic                filt_valid_out,
    output logic                filt_ready_out,
    input  logic [4*Q_W-1:0]    filt_q,
    output logic [4*Q_W-1:0]    q_out,
    output logic                q_update,
    output logic [CNT_W-1:0]    sample_cnt,
    output logic [CNT_W-1:0]    drop_cnt,
    output logic [LAT_W-1:0]    last_latency,
    output logic                busy,
    output logic                timeout_err,
    input  logic                err_clr
);

    localparam int FW   = 3*ACC_W + 3*GYRO_W;
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [4*Q_W-1:0] Q_RST =
        {{(3*Q_W){1'b0}}, Q_W'(Q_ONE)};

    state_t          state;
    logic [WD_W-1:0] wd_cnt;
    logic [LAT_W-1:0] lat_cnt;

    logic [FW-1:0] head;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          drop;
    logic          wd_hit;

    // Watchdog fires only when the pending handshake has not happened.
    assign wd_hit = (TIMEOUT > 0) && (wd_cnt == WD_LAST) &&
                    ((state == ST_ISSUE   && !filt_ready_in) ||
                     (state == ST_COLLECT && !filt_valid_out));

    // A watchdog abort in ISSUE discards the head entry.
    assign pop  = (state == ST_ISSUE) && (filt_ready_in || wd_hit);
    assign push = smp_valid && enable && (!full || pop);
    assign drop = smp_valid && enable && full && !pop;

    assign busy = (state != ST_IDLE) || !empty;

    madgwick_sample_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({smp_gyro, smp_acc}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            wd_cnt         <= '0;
            lat_cnt        <= '0;
            filt_valid_in  <= 1'b0;
            filt_ready_out <= 1'b0;
            filt_acc       <= '0;
            filt_gyro      <= '0;
            q_out          <= Q_RST;
            q_update       <= 1'b0;
            sample_cnt     <= '0;
            drop_cnt       <= '0;
            last_latency   <= '0;
            timeout_err    <= 1'b0;
        end else begin
            q_update <= 1'b0;
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            // Cleared here; a same-cycle timeout below overrides.
            if (err_clr) timeout_err <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (enable && !empty) begin
                        filt_acc      <= head[3*ACC_W-1:0];
                        filt_gyro     <= head[FW-1:3*ACC_W];
                        filt_valid_in <= 1'b1;
                        wd_cnt        <= '0;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (filt_ready_in) begin
                        filt_valid_in  <= 1'b0;
                        filt_ready_out <= 1'b1;
                        lat_cnt        <= '0;
                        wd_cnt         <= '0;
                        state          <= ST_COLLECT;
                    end else if (wd_hit) begin
                        timeout_err   <= 1'b1;
                        filt_valid_in <= 1'b0;
                        state         <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (filt_valid_out) begin
                        q_out          <= filt_q;
                        q_update       <= 1'b1;
                        filt_ready_out <= 1'b0;
                        state          <= ST_IDLE;
                        if (sample_cnt != '1)
                            sample_cnt <= sample_cnt + 1'b1;
                        last_latency <= (lat_cnt == '1) ?
                                        lat_cnt : lat_cnt + 1'b1;
                    end else if (wd_hit) begin
                        timeout_err    <= 1'b1;
                        filt_ready_out <= 1'b0;
                        state          <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (lat_cnt != '1) lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_madgwick_stream_driver.sv
// Directed bench for madgwick_stream_driver.
// Scripted filter model on the handshake pins.
module tb_madgwick_stream_driver;
  import madgwick_stream_driver_pkg::*;

  localparam int AB = 3*ACC_WIDTH;
  localparam int GB = 3*GYRO_WIDTH;
  localparam int QB = 4*Q_WIDTH;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          smp_valid;
  logic [AB-1:0] smp_acc;
  logic [GB-1:0] smp_gyro;
  logic          filt_valid_in;
  logic          filt_ready_in;
  logic [AB-1:0] filt_acc;
  logic [GB-1:0] filt_gyro;
  logic          filt_valid_out;
  logic          filt_ready_out;
  logic [QB-1:0] filt_q;
  logic [QB-1:0] q_out;
  logic          q_update;
  logic [15:0]   sample_cnt;
  logic [15:0]   drop_cnt;
  logic [15:0]   last_latency;
  logic          busy;
  logic          timeout_err;
  logic          err_clr;

  int checks;
  int failures;

  logic [QB-1:0] q_last;

  madgwick_stream_driver #(
    .TIMEOUT (100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .smp_valid      (smp_valid),
    .smp_acc        (smp_acc),
    .smp_gyro       (smp_gyro),
    .filt_valid_in  (filt_valid_in),
    .filt_ready_in  (filt_ready_in),
    .filt_acc       (filt_acc),
    .filt_gyro      (filt_gyro),
    .filt_valid_out (filt_valid_out),
    .filt_ready_out (filt_ready_out),
    .filt_q         (filt_q),
    .q_out          (q_out),
    .q_update       (q_update),
    .sample_cnt     (sample_cnt),
    .drop_cnt       (drop_cnt),
    .last_latency   (last_latency),
    .busy           (busy),
    .timeout_err    (timeout_err),
    .err_clr        (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic chk_b(input string tag,
                       input logic o,
                       input logic e);
    checks++;
    if (o !== e) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, o, e);
    end
  endtask

  task automatic chk_c(input string tag,
                       input logic [15:0] o,
                       input logic [15:0] e);
    checks++;
    if (o !== e) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, o, e);
    end
  endtask

  task automatic chk_a(input string tag,
                       input logic [AB-1:0] o,
                       input logic [AB-1:0] e);
    checks++;
    if (o !== e) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, o, e);
    end
  endtask

  task automatic chk_g(input string tag,
                       input logic [GB-1:0] o,
                       input logic [GB-1:0] e);
    checks++;
    if (o !== e) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, o, e);
    end
  endtask

  task automatic chk_q(input string tag,
                       input logic [QB-1:0] o,
                       input logic [QB-1:0] e);
    checks++;
    if (o !== e) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, o, e);
    end
  endtask

  function automatic logic [AB-1:0] mk_acc(input int i);
    return {11'(i*3 + 1), 11'(i*5 + 2), 11'(i*7 + 3)};
  endfunction

  function automatic logic [GB-1:0] mk_gyro(input int i);
    return {14'(i*11 + 5), 14'(i*13 + 6), 14'(i*17 + 7)};
  endfunction

  function automatic logic [QB-1:0] mk_q(input int i);
    return {16'(i + 16'h0200), 16'(i + 16'h0100),
            16'(i), 16'(i + 16'h3000)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AB-1:0] a,
                      input logic [GB-1:0] g);
    smp_valid = 1'b1;
    smp_acc   = a;
    smp_gyro  = g;
    tick();
    smp_valid = 1'b0;
  endtask

  task automatic txn(input logic [AB-1:0] ea,
                     input logic [GB-1:0] eg,
                     input int dly,
                     input int lat,
                     input logic [QB-1:0] q);
    int n;
    n = 0;
    while (filt_valid_in !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk_b("valid_in_rise", filt_valid_in, 1'b1);
    chk_a("filt_acc", filt_acc, ea);
    chk_g("filt_gyro", filt_gyro, eg);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk_b("bp_valid", filt_valid_in, 1'b1);
      chk_a("bp_acc", filt_acc, ea);
      chk_g("bp_gyro", filt_gyro, eg);
    end
    filt_ready_in = 1'b1;
    tick();
    filt_ready_in = 1'b0;
    chk_b("issue_valid_drop", filt_valid_in, 1'b0);
    chk_b("collect_ready", filt_ready_out, 1'b1);
    for (int i = 1; i < lat; i++) tick();
    filt_valid_out = 1'b1;
    filt_q         = q;
    tick();
    filt_valid_out = 1'b0;
    chk_q("q_out", q_out, q);
    chk_b("q_update_hi", q_update, 1'b1);
    chk_c("last_latency", last_latency, 16'(lat));
    chk_b("ready_out_drop", filt_ready_out, 1'b0);
    tick();
    chk_b("q_update_lo", q_update, 1'b0);
  endtask

  initial begin
    logic [AB-1:0] a1;
    logic [GB-1:0] g1;
    logic [QB-1:0] q1;

    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    enable         = 1'b0;
    smp_valid      = 1'b0;
    smp_acc        = '0;
    smp_gyro       = '0;
    filt_ready_in  = 1'b0;
    filt_valid_out = 1'b0;
    filt_q         = '0;
    err_clr        = 1'b0;
    tick();
    tick();

    chk_q("rst_q_out", q_out, 64'h0000_0000_0000_4000);
    chk_b("rst_valid_in", filt_valid_in, 1'b0);
    chk_b("rst_ready_out", filt_ready_out, 1'b0);
    chk_a("rst_acc", filt_acc, '0);
    chk_b("rst_busy", busy, 1'b0);
    chk_c("rst_sample_cnt", sample_cnt, 16'h0);
    rst    = 1'b0;
    enable = 1'b1;
    tick();

    a1 = {11'h0C4, 11'h14A, 11'h7B8};
    g1 = {14'h3F54, 14'h005C, 14'h3F1F};
    q1 = {16'h0002, 16'hFFF0, 16'h0010, 16'h3FFF};
    push(a1, g1);
    chk_b("one_valid_lat0", filt_valid_in, 1'b0);
    chk_b("one_busy", busy, 1'b1);
    txn(a1, g1, 2, 20, q1);
    chk_c("one_sample_cnt", sample_cnt, 16'd1);
    chk_b("one_busy_done", busy, 1'b0);

    for (int i = 0; i < 6; i++) begin
      smp_valid = 1'b1;
      smp_acc   = mk_acc(i);
      smp_gyro  = mk_gyro(i);
      tick();
    end
    smp_valid = 1'b0;
    chk_c("ovf_drop_cnt", drop_cnt, 16'd2);
    for (int i = 0; i < 4; i++)
      txn(mk_acc(i), mk_gyro(i), 0, 1, mk_q(i));
    chk_c("ovf_sample_cnt", sample_cnt, 16'd5);
    chk_b("ovf_busy", busy, 1'b0);

    push(mk_acc(10), mk_gyro(10));
    push(mk_acc(11), mk_gyro(11));
    txn(mk_acc(10), mk_gyro(10), 50, 5, mk_q(10));
    txn(mk_acc(11), mk_gyro(11), 0, 3, mk_q(11));
    chk_c("bp_sample_cnt", sample_cnt, 16'd7);
    chk_b("bp_busy", busy, 1'b0);

    smp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp_acc  = mk_acc(20 + i);
      smp_gyro = mk_gyro(20 + i);
      tick();
    end
    smp_acc       = mk_acc(24);
    smp_gyro      = mk_gyro(24);
    filt_ready_in = 1'b1;
    tick();
    smp_valid     = 1'b0;
    filt_ready_in = 1'b0;
    chk_c("pf_drop_same", drop_cnt, 16'd2);
    chk_b("pf_collect", filt_ready_out, 1'b1);
    push(mk_acc(25), mk_gyro(25));
    chk_c("pf_still_full", drop_cnt, 16'd3);
    filt_valid_out = 1'b1;
    filt_q         = mk_q(20);
    tick();
    filt_valid_out = 1'b0;
    chk_q("pf_q0", q_out, mk_q(20));
    tick();
    for (int i = 1; i < 5; i++)
      txn(mk_acc(20 + i), mk_gyro(20 + i), 0, 1,
          mk_q(20 + i));
    chk_c("pf_sample_cnt", sample_cnt, 16'd12);
    q_last = mk_q(24);

    push(mk_acc(30), mk_gyro(30));
    tick();
    chk_b("wd_issue", filt_valid_in, 1'b1);
    filt_ready_in = 1'b1;
    tick();
    filt_ready_in = 1'b0;
    repeat (99) tick();
    chk_b("wd_pre_err", timeout_err, 1'b0);
    chk_b("wd_pre_ready", filt_ready_out, 1'b1);
    tick();
    chk_b("wd_err", timeout_err, 1'b1);
    chk_b("wd_ready_out", filt_ready_out, 1'b0);
    chk_b("wd_idle", busy, 1'b0);
    chk_c("wd_sample_cnt", sample_cnt, 16'd12);
    chk_q("wd_q_keep", q_out, q_last);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk_b("wd_clr", timeout_err, 1'b0);

    push(mk_acc(31), mk_gyro(31));
    tick();
    chk_b("wdi_issue", filt_valid_in, 1'b1);
    repeat (99) tick();
    chk_b("wdi_pre_valid", filt_valid_in, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk_b("wdi_valid_drop", filt_valid_in, 1'b0);
    chk_b("wdi_err_wins", timeout_err, 1'b1);
    chk_b("wdi_popped", busy, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk_b("wdi_clr", timeout_err, 1'b0);

    enable = 1'b0;
    push(mk_acc(40), mk_gyro(40));
    chk_b("dis_busy", busy, 1'b0);
    chk_c("dis_drop", drop_cnt, 16'd3);
    enable = 1'b1;

    push(mk_acc(41), mk_gyro(41));
    tick();
    filt_ready_in = 1'b1;
    tick();
    filt_ready_in = 1'b0;
    tick();
    chk_b("mid_collect", filt_ready_out, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_q("ar_q_out", q_out, 64'h0000_0000_0000_4000);
    chk_b("ar_busy", busy, 1'b0);
    chk_b("ar_ready_out", filt_ready_out, 1'b0);
    chk_c("ar_sample_cnt", sample_cnt, 16'd0);
    chk_c("ar_drop_cnt", drop_cnt, 16'd0);
    chk_c("ar_latency", last_latency, 16'd0);
    tick();
    rst = 1'b0;
    tick();
    chk_b("post_rst_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
